i2c_master_seq: RTL and testbench
=================================

# i2c_master_seq

Hardware I2C master sequencer for the bus-mapped peripheral space. It replaces software bit-banging of the open-drain SDA/SCL pins with a quarter-period state machine that runs START, byte-write, byte-read and STOP sequences from one control write. It honours slave clock stretching and reports ACK/NACK. Pin polarity matches the existing bit-level I2C register: an output of 1 pulls the line low, and 0 releases it.

## Interface
- DIV_RESET, 16'd124, reset value of the quarter-period divider (50 MHz clock, 100 kHz SCL).
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset (0 = reset).
- Addr  in  3  register select.
- DataWr  in  16  write data.
- DataRd  out  16  read data; combinational from Addr and registers.
- En  in  1  block select.
- Wr  in  1  write strobe; the write is taken on the Clk edge where Wr & En = 1.
- Rd  in  1  read strobe; reads have no side effects.
- SdaOut  out  1  1 = drive SDA low.
- SdaIn  in  1  sampled SDA line.
- SclOut  out  1  1 = drive SCL low.
- SclIn  in  1  sampled SCL line.

## Operation
- Registers:
  - Addr 0 CTRL, write bits: [0] START, [1] WRITE, [2] STOP, [3] READ, [4] AckOut (level driven on the 9th bit of a READ; 0 = ACK).
  - Addr 0 STATUS, read bits: {13'h0, Done, RxAck, Busy}.
  - Addr 1 TX[7:0], read/write.
  - Addr 2 RX[7:0], read-only.
  - Addr 3 DIV[15:0], read/write.
  - Every other address reads 16'h0000. Unused upper bits read 0.
- Writes to CTRL or DIV while Busy = 1 are ignored. Writes to TX while busy are also ignored.
- An accepted CTRL write clears Done. If any command bit is set, it also sets Busy. The write then executes, in order: START (if set), then WRITE or READ (WRITE wins if both are set), then STOP (if set). A CTRL write with no command bits set only clears Done.
- FSM states: IDLE, START, BYTE, STOP.
  - Each non-IDLE state steps through phases P0..P3. Each phase lasts DIV+1 Clk cycles.
  - In phase P1 (SCL released), the phase counter is held at 0 while SclIn = 0. This implements clock stretching.
- START phases:
  - P0: release SDA. SCL stays as it was, so a repeated START is legal.
  - P1: release SCL.
  - P2: drive SDA low.
  - P3: drive SCL low.
- BYTE is 9 bits, sent MSB first. Each bit runs:
  - P0: drive SCL low and set the SDA level.
  - P1: release SCL.
  - P2: SCL high; SdaIn is sampled on the last cycle of P2.
  - P3: drive SCL low.
- WRITE: bits 1-8 drive TX[7:0], with 1 = released. On bit 9, SDA is released and the sampled value is loaded into RxAck (1 = NACK).
- READ: on bits 1-8, SDA is released and the sampled values are shifted into RX. On bit 9, AckOut is driven.
- STOP phases:
  - P0: SCL low, SDA low.
  - P1: release SCL.
  - P2: release SDA.
  - P3: hold.
- When the sequence ends, Busy goes to 0 and Done goes to 1 on the same edge.
- Pin state between commands:
  - After a sequence with no STOP, SCL is held low and SDA keeps its last driven level. The bus stays owned.
  - After STOP, both lines are released.
- No arbitration-loss detection; single-master bus only.

## Timing
- Reset values:
  - SdaOut = 0, SclOut = 0 (both lines released).
  - Busy = 0, Done = 0, RxAck = 0.
  - TX = 0, RX = 0, DIV = DIV_RESET.
  - FSM in IDLE.
- Reset asserted mid-sequence aborts the sequence and releases both pins on the same edge. No STOP is generated.
- Busy rises on the edge that accepts the CTRL write. P0 of the first state starts on the next cycle.
- Without stretching, Busy stays high for exactly Q*(DIV+1) cycles:
  - Q = 4·START + 36·(WRITE|READ) + 4·STOP, where each term counts 1 if the bit is set.
  - Every SclIn-low cycle during P1 adds exactly one cycle.
- DIV = 0 is legal and gives 1-cycle phases.
- SdaOut and SclOut are registered and change only at phase boundaries.
- RX and RxAck update on the edge at the end of the sampling P2. RX and RxAck hold their values until the next READ or WRITE respectively.
- A write accepted on the same edge Busy falls is ignored. The first accepted write is on the cycle after Busy = 0 is visible.

## Test plan
- Reset held low 2 cycles -> SdaOut = 0, SclOut = 0. Reading Addr 3 returns 16'h007C; Addr 0 and Addr 5 return 0.
- DIV = 1, TX = 8'hA5, CTRL = 16'h0007, slave model ACKs -> SDA bits 1,0,1,0,0,1,0,1 stable across each SCL high. Busy is high exactly 88 cycles. STATUS = 16'h0004.
- DIV = 0, CTRL = 16'h0018, slave returns 8'h3C -> RX = 8'h3C. SDA is released on bit 9. Busy is high 36 cycles. Done = 1.
- Write with the slave NACKing bit 9 -> RxAck = 1 and STATUS = 16'h0006.
- Slave holds SclIn low 10 cycles during P1 of bit 3 -> Busy duration grows by exactly 10 cycles. SDA does not change while SCL is held low.
- CTRL write while Busy -> ignored and the sequence continues. Reset = 0 mid-byte -> next edge: SdaOut = 0, SclOut = 0, Busy = 0.

Source files
------------

// File: rtl/i2c_master_seq_if.sv
// Register-bus and I2C pin bundle for i2c_master_seq; the CPU/bench side uses
// the master modport, the sequencer uses the slave modport.
interface i2c_master_seq_if;
    logic [2:0]  Addr;
    logic [15:0] DataWr;
    logic [15:0] DataRd;
    logic        En;
    logic        Wr;
    logic        Rd;
    logic        SdaOut;
    logic        SdaIn;
    logic        SclOut;
    logic        SclIn;

    modport slave (
        input  Addr, DataWr, En, Wr, Rd, SdaIn, SclIn,
        output DataRd, SdaOut, SclOut
    );

    modport master (
        output Addr, DataWr, En, Wr, Rd, SdaIn, SclIn,
        input  DataRd, SdaOut, SclOut
    );
endinterface

// File: rtl/i2c_master_seq.sv
// I2C master sequencer: START / byte write-read / STOP from one CTRL write, 4 phases of DIV+1 cycles each.
// Register reads are combinational; writes while busy are dropped; slave SCL stretching pauses phase P1.
module i2c_master_seq #(
    parameter logic [15:0] DIV_RESET = 16'd124
) (
    input  logic             Clk,
    input  logic             Reset,
    i2c_master_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_BYTE, S_STOP} state_t;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_phase, w_phase_nx;
    logic [15:0] r_cnt, w_cnt_nx;
    logic [3:0]  r_bit, w_bit_nx;
    logic        r_do_rw, w_do_rw_nx;
    logic        r_do_stop, w_do_stop_nx;
    logic        r_is_read, w_is_read_nx;
    logic        r_ack_out, w_ack_out_nx;
    logic [7:0]  r_tx, w_tx_nx;
    logic [7:0]  r_rx, w_rx_nx;
    logic [15:0] r_div, w_div_nx;
    logic        r_done, w_done_nx;
    logic        r_rxack, w_rxack_nx;
    logic        r_sda, w_sda_nx;
    logic        r_scl, w_scl_nx;
    logic        w_busy, w_wr, w_last, w_enter;
    logic [2:0]  w_tx_idx;
    logic        w_unused;

    assign w_busy   = (r_state != S_IDLE);
    assign w_wr     = bus.Wr & bus.En & ~w_busy;
    assign w_last   = (r_cnt == r_div);
    assign w_tx_idx = 3'd7 - w_bit_nx[2:0];
    assign w_unused = bus.Rd;

    assign bus.SdaOut = r_sda;
    assign bus.SclOut = r_scl;

    always_comb begin
        bus.DataRd = 16'h0000;
        case (bus.Addr)
            3'd0:    bus.DataRd = {13'h0, r_done, r_rxack, w_busy};
            3'd1:    bus.DataRd = {8'h0, r_tx};
            3'd2:    bus.DataRd = {8'h0, r_rx};
            3'd3:    bus.DataRd = r_div;
            default: bus.DataRd = 16'h0000;
        endcase
    end

    always_comb begin
        w_state_nx   = r_state;
        w_phase_nx   = r_phase;
        w_cnt_nx     = r_cnt;
        w_bit_nx     = r_bit;
        w_do_rw_nx   = r_do_rw;
        w_do_stop_nx = r_do_stop;
        w_is_read_nx = r_is_read;
        w_ack_out_nx = r_ack_out;
        w_tx_nx      = r_tx;
        w_rx_nx      = r_rx;
        w_div_nx     = r_div;
        w_done_nx    = r_done;
        w_rxack_nx   = r_rxack;
        w_sda_nx     = r_sda;
        w_scl_nx     = r_scl;
        w_enter      = 1'b0;

        if (w_wr) begin
            case (bus.Addr)
                3'd0: begin
                    w_done_nx = 1'b0;
                    if (|bus.DataWr[3:0]) begin
                        w_do_rw_nx   = bus.DataWr[1] | bus.DataWr[3];
                        w_do_stop_nx = bus.DataWr[2];
                        w_is_read_nx = bus.DataWr[3] & ~bus.DataWr[1];
                        w_ack_out_nx = bus.DataWr[4];
                        w_state_nx   = bus.DataWr[0] ? S_START :
                                       (w_do_rw_nx ? S_BYTE : S_STOP);
                        w_phase_nx   = 2'd0;
                        w_cnt_nx     = 16'd0;
                        w_bit_nx     = 4'd0;
                        w_enter      = 1'b1;
                    end
                end
                3'd1:    w_tx_nx  = bus.DataWr[7:0];
                3'd3:    w_div_nx = bus.DataWr;
                default: ;
            endcase
        end else if (w_busy) begin
            // A slave holding SCL low keeps P1 from timing out
            if (r_phase == 2'd1 && !bus.SclIn) begin
                w_cnt_nx = 16'd0;
            end else if (!w_last) begin
                w_cnt_nx = r_cnt + 16'd1;
            end else begin
                w_cnt_nx = 16'd0;
                w_enter  = 1'b1;
                if (r_state == S_BYTE && r_phase == 2'd2) begin
                    if (r_bit != 4'd8) begin
                        if (r_is_read)
                            w_rx_nx = {r_rx[6:0], bus.SdaIn};
                    end else if (!r_is_read) begin
                        w_rxack_nx = bus.SdaIn;
                    end
                end
                if (r_phase != 2'd3) begin
                    w_phase_nx = r_phase + 2'd1;
                end else begin
                    w_phase_nx = 2'd0;
                    case (r_state)
                        S_START: begin
                            w_bit_nx   = 4'd0;
                            w_state_nx = r_do_rw ? S_BYTE : (r_do_stop ? S_STOP : S_IDLE);
                        end
                        S_BYTE: begin
                            if (r_bit != 4'd8)
                                w_bit_nx = r_bit + 4'd1;
                            else
                                w_state_nx = r_do_stop ? S_STOP : S_IDLE;
                        end
                        default: w_state_nx = S_IDLE;
                    endcase
                    if (w_state_nx == S_IDLE)
                        w_done_nx = 1'b1;
                end
            end
        end

        // Pins are set once, on the edge that enters a phase
        if (w_enter) begin
            case (w_state_nx)
                S_START: begin
                    case (w_phase_nx)
                        2'd0:    w_sda_nx = 1'b0;
                        2'd1:    w_scl_nx = 1'b0;
                        2'd2:    w_sda_nx = 1'b1;
                        default: w_scl_nx = 1'b1;
                    endcase
                end
                S_BYTE: begin
                    case (w_phase_nx)
                        2'd0: begin
                            w_scl_nx = 1'b1;
                            if (w_bit_nx == 4'd8)
                                w_sda_nx = w_is_read_nx ? ~w_ack_out_nx : 1'b0;
                            else
                                w_sda_nx = w_is_read_nx ? 1'b0 : ~r_tx[w_tx_idx];
                        end
                        2'd1:    w_scl_nx = 1'b0;
                        2'd3:    w_scl_nx = 1'b1;
                        default: ;
                    endcase
                end
                S_STOP: begin
                    case (w_phase_nx)
                        2'd0: begin
                            w_scl_nx = 1'b1;
                            w_sda_nx = 1'b1;
                        end
                        2'd1:    w_scl_nx = 1'b0;
                        2'd2:    w_sda_nx = 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_phase   <= 2'd0;
            r_cnt     <= 16'd0;
            r_bit     <= 4'd0;
            r_do_rw   <= 1'b0;
            r_do_stop <= 1'b0;
            r_is_read <= 1'b0;
            r_ack_out <= 1'b0;
            r_tx      <= 8'h00;
            r_rx      <= 8'h00;
            r_div     <= DIV_RESET;
            r_done    <= 1'b0;
            r_rxack   <= 1'b0;
            r_sda     <= 1'b0;
            r_scl     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_phase   <= w_phase_nx;
            r_cnt     <= w_cnt_nx;
            r_bit     <= w_bit_nx;
            r_do_rw   <= w_do_rw_nx;
            r_do_stop <= w_do_stop_nx;
            r_is_read <= w_is_read_nx;
            r_ack_out <= w_ack_out_nx;
            r_tx      <= w_tx_nx;
            r_rx      <= w_rx_nx;
            r_div     <= w_div_nx;
            r_done    <= w_done_nx;
            r_rxack   <= w_rxack_nx;
            r_sda     <= w_sda_nx;
            r_scl     <= w_scl_nx;
        end
    end
endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: a slave model answers on the wire, expected SDA bits are queued
// when a command is issued and popped as each SCL-high window closes.
module tb_i2c_master_seq;
    logic Clk;
    logic Reset;
    logic stretch;
    logic slave_low;
    int   n_chk;
    int   n_pass;
    logic exp_q[$];
    logic [15:0] rd;

    i2c_master_seq_if bus();

    i2c_master_seq #(.DIV_RESET(16'd124)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.SclIn = ~bus.SclOut & ~stretch;
    assign bus.SdaIn = ~bus.SdaOut & ~slave_low;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge Clk);
        bus.Addr   = a;
        bus.DataWr = d;
        bus.En     = 1'b1;
        bus.Wr     = 1'b1;
        @(negedge Clk);
        bus.En     = 1'b0;
        bus.Wr     = 1'b0;
        bus.Addr   = 3'd0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge Clk);
        bus.Addr = a;
        bus.Rd   = 1'b1;
        #1 d = bus.DataRd;
        bus.Rd   = 1'b0;
        bus.Addr = 3'd0;
    endtask

    function automatic logic slave_bit(input logic is_wr, input logic is_rd, input logic ack,
                                       input logic [7:0] rb, input int w);
        if (is_wr)
            return ack && (w == 8);
        if (is_rd && w < 8)
            return ~rb[7-w];
        return 1'b0;
    endfunction

    // Issues one CTRL command, plays the slave, and checks every closed SCL-high window.
    task automatic run_cmd(input logic [15:0] ctrl, input logic [7:0] tx, input logic [7:0] rb,
                           input logic ack, input int stretch_bit, input int inj_cyc,
                           input int abort_cyc, input int exp_cyc);
        int   cyc, w, st_cnt;
        logic is_wr, is_rd, prev_sl, prev_sclout, sl, sd, in_win, win_sda, unstable;
        logic st_req, st_sda, aborted, e;
        is_wr = ctrl[1];
        is_rd = ctrl[3] & ~ctrl[1];
        if (is_wr) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(tx[i]);
            exp_q.push_back(~ack);
        end else if (is_rd) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(rb[i]);
            exp_q.push_back(ctrl[4]);
        end
        w = 0; cyc = 0; st_cnt = 0;
        st_req = (stretch_bit >= 0); st_sda = 1'b0;
        aborted = 1'b0; in_win = 1'b0; win_sda = 1'b0; unstable = 1'b0;
        slave_low   = slave_bit(is_wr, is_rd, ack, rb, w);
        prev_sl     = ~bus.SclOut & ~stretch;
        prev_sclout = bus.SclOut;
        reg_write(3'd0, ctrl);
        for (int g = 0; g < 5000; g++) begin
            if (bus.DataRd[0] !== 1'b1) break;
            cyc++;
            if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0) begin
                    stretch = 1'b0;
                    check_eq("sda_held_in_stretch", 32'(bus.SdaOut), 32'(st_sda));
                end
            end else if (st_req && w == stretch_bit && !bus.SclOut && prev_sclout) begin
                stretch = 1'b1;
                st_cnt  = 10;
                st_sda  = bus.SdaOut;
                st_req  = 1'b0;
            end
            sl = ~bus.SclOut & ~stretch;
            sd = ~bus.SdaOut & ~slave_low;
            if (sl && !prev_sl) begin
                in_win = 1'b1; win_sda = sd; unstable = 1'b0;
            end else if (sl && in_win && sd !== win_sda) begin
                unstable = 1'b1;
            end
            if (!sl && prev_sl && in_win) begin
                in_win = 1'b0;
                if (exp_q.size() == 0) begin
                    check_eq("extra_bit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sda_bit", 32'({unstable, win_sda}), 32'({1'b0, e}));
                end
                w++;
                slave_low = slave_bit(is_wr, is_rd, ack, rb, w);
            end
            prev_sl     = sl;
            prev_sclout = bus.SclOut;
            if (inj_cyc > 0 && cyc == inj_cyc) begin
                bus.DataWr = 16'h0008; bus.En = 1'b1; bus.Wr = 1'b1;
            end
            if (inj_cyc > 0 && cyc == inj_cyc + 1) begin
                bus.En = 1'b0; bus.Wr = 1'b0;
            end
            if (abort_cyc > 0 && cyc == abort_cyc) begin
                Reset = 1'b0;
                @(negedge Clk);
                check_eq("abort_sda", 32'(bus.SdaOut), 32'd0);
                check_eq("abort_scl", 32'(bus.SclOut), 32'd0);
                check_eq("abort_busy", 32'(bus.DataRd[0]), 32'd0);
                Reset = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        stretch = 1'b0; slave_low = 1'b0; bus.En = 1'b0; bus.Wr = 1'b0;
        if (aborted) begin
            exp_q.delete();
        end else begin
            if (bus.DataRd[0] === 1'b1) check_eq("busy_timeout", 32'd1, 32'd0);
            check_eq("busy_cycles", 32'(cyc), 32'(exp_cyc));
            check_eq("bits_left", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        stretch = 1'b0; slave_low = 1'b0;
        bus.Addr = 3'd0; bus.DataWr = 16'h0; bus.En = 1'b0; bus.Wr = 1'b0; bus.Rd = 1'b0;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check_eq("rst_sda", 32'(bus.SdaOut), 32'd0);
        check_eq("rst_scl", 32'(bus.SclOut), 32'd0);
        Reset = 1'b1;
        reg_read(3'd3, rd); check_eq("rst_div", 32'(rd), 32'h007C);
        reg_read(3'd0, rd); check_eq("rst_status", 32'(rd), 32'h0);
        reg_read(3'd5, rd); check_eq("rd_addr5", 32'(rd), 32'h0);
        reg_read(3'd2, rd); check_eq("rst_rx", 32'(rd), 32'h0);

        // START + write A5 + STOP, slave ACKs
        reg_write(3'd3, 16'd1);
        reg_write(3'd1, 16'h00A5);
        reg_read(3'd1, rd); check_eq("tx_rb", 32'(rd), 32'h00A5);
        run_cmd(16'h0007, 8'hA5, 8'h00, 1'b1, -1, 0, 0, 88);
        reg_read(3'd0, rd); check_eq("status_wr_ack", 32'(rd), 32'h0004);
        check_eq("stop_sda", 32'(bus.SdaOut), 32'd0);
        check_eq("stop_scl", 32'(bus.SclOut), 32'd0);

        // Read 3C with AckOut=1 at DIV=0; no STOP so SCL stays held
        reg_write(3'd3, 16'd0);
        run_cmd(16'h0018, 8'h00, 8'h3C, 1'b0, -1, 0, 0, 36);
        reg_read(3'd2, rd); check_eq("rx_val", 32'(rd), 32'h003C);
        reg_read(3'd0, rd); check_eq("status_rd", 32'(rd), 32'h0004);
        check_eq("owned_scl", 32'(bus.SclOut), 32'd1);

        // STOP alone releases the bus
        run_cmd(16'h0004, 8'h00, 8'h00, 1'b0, -1, 0, 0, 4);
        check_eq("stop_only_sda", 32'(bus.SdaOut), 32'd0);
        check_eq("stop_only_scl", 32'(bus.SclOut), 32'd0);

        // Command-less CTRL write just clears Done
        reg_write(3'd0, 16'h0000);
        reg_read(3'd0, rd); check_eq("done_clear", 32'(rd), 32'h0000);

        // Slave NACKs
        reg_write(3'd1, 16'h005A);
        run_cmd(16'h0007, 8'h5A, 8'h00, 1'b0, -1, 0, 0, 44);
        reg_read(3'd0, rd); check_eq("status_nack", 32'(rd), 32'h0006);
        reg_read(3'd2, rd); check_eq("rx_held", 32'(rd), 32'h003C);

        // Stretch 10 cycles in P1 of bit 3
        reg_write(3'd3, 16'd1);
        reg_write(3'd1, 16'h00A5);
        run_cmd(16'h0007, 8'hA5, 8'h00, 1'b1, 2, 0, 0, 98);
        reg_read(3'd0, rd); check_eq("status_stretch", 32'(rd), 32'h0004);

        // CTRL write while busy is ignored
        run_cmd(16'h0007, 8'hA5, 8'h00, 1'b1, -1, 20, 0, 88);
        reg_read(3'd0, rd); check_eq("status_inject", 32'(rd), 32'h0004);
        reg_read(3'd3, rd); check_eq("div_kept", 32'(rd), 32'h0001);

        // Reset mid-byte
        run_cmd(16'h0007, 8'hA5, 8'h00, 1'b1, -1, 0, 33, 0);
        reg_read(3'd3, rd); check_eq("div_after_abort", 32'(rd), 32'h007C);
        reg_read(3'd1, rd); check_eq("tx_after_abort", 32'(rd), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
